// File: rtl/mux_scan_reg_pkg.sv
// Shared definitions for the registered scanning channel multiplexer:
// mode encodings and a constant-evaluable ceiling log2.
package mux_scan_reg_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2; clog2(1) == 0, callers clamp the result to at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Circular priority search: the first channel above ptr_i (wrapping) whose
// mask bit is set, and whether that search wrapped past the top channel.
module mux_scan_next
  import mux_scan_reg_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      ptr_i,
  input  logic [(1<<SEL_W)-1:0] ch_mask_i,
  output logic [SEL_W-1:0]      next_o,
  output logic                  wrapped_o
);

  localparam int N_CH = 1 << SEL_W;

  logic [SEL_W-1:0] idx;
  logic             found;

  // Offset N_CH lands back on ptr_i itself, covering the single-bit mask case.
  always_comb begin
    next_o = ptr_i;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = ptr_i + SEL_W'(i);
      if (!found && ch_mask_i[idx]) begin
        next_o = idx;
        found  = 1'b1;
      end
    end
  end

  assign wrapped_o = (next_o <= ptr_i);

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N:1 channel multiplexer with enable; direct select or a scan
// pointer that dwells DWELL cycles on each channel enabled in ch_mask.
module mux_scan_reg
  import mux_scan_reg_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 1,
  parameter int DWELL  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           mode,
  input  logic [SEL_W-1:0]               select,
  input  logic [(1<<SEL_W)-1:0]          ch_mask,
  input  logic [(1<<SEL_W)*DATA_W-1:0]   data,
  output logic [DATA_W-1:0]              out,
  output logic                           out_valid,
  output logic [SEL_W-1:0]               cur_ch,
  output logic                           wrap
);

  localparam int N_CH   = 1 << SEL_W;
  localparam int DCNT_W = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic              wrap_q, wrap_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              mode_q, mode_d;

  logic [SEL_W-1:0]  pick;
  logic [DATA_W-1:0] ch_term [N_CH];
  logic [DATA_W-1:0] picked;
  logic [SEL_W-1:0]  ptr_nx;
  logic              ptr_wrap;
  logic [DCNT_W-1:0] dcnt_eff;

  assign pick = (mode == MODE_SCAN) ? ptr_q : select;

  // AND-OR extraction keeps every part-select constant.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_term[gi] = data[gi*DATA_W +: DATA_W] & {DATA_W{pick == SEL_W'(gi)}};
    end
  endgenerate

  always_comb begin
    picked = '0;
    for (int k = 0; k < N_CH; k++) begin
      picked = picked | ch_term[k];
    end
  end

  mux_scan_next #(
    .SEL_W (SEL_W)
  ) u_next (
    .ptr_i     (ptr_q),
    .ch_mask_i (ch_mask),
    .next_o    (ptr_nx),
    .wrapped_o (ptr_wrap)
  );

  // First scan cycle after direct mode restarts the dwell on the held pointer.
  assign dcnt_eff = (mode_q == MODE_SCAN) ? dcnt_q : '0;

  always_comb begin
    out_d       = '0;
    out_valid_d = 1'b0;
    cur_ch_d    = cur_ch_q;
    wrap_d      = 1'b0;
    ptr_d       = ptr_q;
    dcnt_d      = dcnt_q;
    mode_d      = mode;
    if (enable) begin
      if (mode == MODE_DIRECT) begin
        out_d       = picked;
        out_valid_d = 1'b1;
        cur_ch_d    = select;
      end else if (ch_mask == '0) begin
        dcnt_d = '0;
      end else if (!ch_mask[ptr_q]) begin
        ptr_d  = ptr_nx;
        dcnt_d = '0;
        wrap_d = ptr_wrap;
      end else begin
        out_d       = picked;
        out_valid_d = 1'b1;
        cur_ch_d    = ptr_q;
        if (dcnt_eff == DCNT_LAST) begin
          dcnt_d = '0;
          ptr_d  = ptr_nx;
          wrap_d = ptr_wrap;
        end else begin
          dcnt_d = dcnt_eff + DCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cur_ch_q    <= '0;
      wrap_q      <= 1'b0;
      ptr_q       <= '0;
      dcnt_q      <= '0;
      mode_q      <= MODE_DIRECT;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cur_ch_q    <= cur_ch_d;
      wrap_q      <= wrap_d;
      ptr_q       <= ptr_d;
      dcnt_q      <= dcnt_d;
      mode_q      <= mode_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cur_ch    = cur_ch_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: three instances (DWELL 1, 2, 3) share one stimulus;
// directed tables and sequences plus a randomized run against a reference model.
module tb_mux_scan_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  select = '0;
  logic [7:0]  ch_mask = '0;
  logic [31:0] data = 32'h8765_4321;

  logic [3:0] o_out   [3];
  logic       o_valid [3];
  logic [2:0] o_cur   [3];
  logic       o_wrap  [3];

  mux_scan_reg #(.SEL_W(3), .DATA_W(4), .DWELL(1)) u_dw1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .select(select),
    .ch_mask(ch_mask), .data(data), .out(o_out[0]), .out_valid(o_valid[0]),
    .cur_ch(o_cur[0]), .wrap(o_wrap[0]));

  mux_scan_reg #(.SEL_W(3), .DATA_W(4), .DWELL(2)) u_dw2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .select(select),
    .ch_mask(ch_mask), .data(data), .out(o_out[1]), .out_valid(o_valid[1]),
    .cur_ch(o_cur[1]), .wrap(o_wrap[1]));

  mux_scan_reg #(.SEL_W(3), .DATA_W(4), .DWELL(3)) u_dw3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .select(select),
    .ch_mask(ch_mask), .data(data), .out(o_out[2]), .out_valid(o_valid[2]),
    .cur_ch(o_cur[2]), .wrap(o_wrap[2]));

  int tests = 0;
  int fails = 0;

  // Reference model: pointer, cycles already spent on it, previous-cycle mode.
  int dw_tab [3] = '{1, 2, 3};
  int m_ptr [3], m_cnt [3], m_cur [3], m_out [3], m_valid [3], m_wrap [3];
  bit m_prev_scan;

  function automatic int chv(input int k);
    return int'((data >> (4 * k)) & 32'hF);
  endfunction

  function automatic int nextp(input int p, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) begin
      if (m[(p + k) % 8]) return (p + k) % 8;
    end
    return p;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_ptr[j] = 0; m_cnt[j] = 0; m_cur[j] = 0;
      m_out[j] = 0; m_valid[j] = 0; m_wrap[j] = 0;
    end
    m_prev_scan = 1'b0;
  endtask

  task automatic model_step();
    int np;
    int spent;
    for (int j = 0; j < 3; j++) begin
      m_wrap[j] = 0;
      m_out[j] = 0;
      m_valid[j] = 0;
      if (!enable) begin
      end else if (!mode) begin
        m_out[j] = chv(int'(select)); m_valid[j] = 1; m_cur[j] = int'(select);
      end else if (ch_mask == 8'h00) begin
        m_cnt[j] = 0;
      end else if (!ch_mask[m_ptr[j]]) begin
        np = nextp(m_ptr[j], ch_mask);
        m_wrap[j] = (np <= m_ptr[j]) ? 1 : 0;
        m_ptr[j] = np;
        m_cnt[j] = 0;
      end else begin
        m_out[j] = chv(m_ptr[j]); m_valid[j] = 1; m_cur[j] = m_ptr[j];
        spent = (m_prev_scan ? m_cnt[j] : 0) + 1;
        if (spent >= dw_tab[j]) begin
          np = nextp(m_ptr[j], ch_mask);
          m_wrap[j] = (np <= m_ptr[j]) ? 1 : 0;
          m_ptr[j] = np;
          m_cnt[j] = 0;
        end else begin
          m_cnt[j] = spent;
        end
      end
    end
    m_prev_scan = mode;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit use_model);
    @(posedge clk);
    #1;
    model_step();
    $display("[TB] t=%0t en=%0b md=%0b sel=%0d mask=%02h cur=%0d,%0d,%0d out=%h,%h,%h v=%0b%0b%0b w=%0b%0b%0b",
             $time, enable, mode, select, ch_mask, o_cur[0], o_cur[1], o_cur[2],
             o_out[0], o_out[1], o_out[2], o_valid[0], o_valid[1], o_valid[2],
             o_wrap[0], o_wrap[1], o_wrap[2]);
    if (use_model) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("rnd_out_dw%0d", j + 1), int'(o_out[j]), m_out[j]);
        chk($sformatf("rnd_valid_dw%0d", j + 1), int'(o_valid[j]), m_valid[j]);
        chk($sformatf("rnd_cur_dw%0d", j + 1), int'(o_cur[j]), m_cur[j]);
        chk($sformatf("rnd_wrap_dw%0d", j + 1), int'(o_wrap[j]), m_wrap[j]);
      end
    end
  endtask

  // Called 1 time unit after a rising edge: asserts reset between edges,
  // checks the outputs cleared without a clock, then releases after an edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rst_out_dw%0d", j + 1), int'(o_out[j]), 0);
      chk($sformatf("rst_valid_dw%0d", j + 1), int'(o_valid[j]), 0);
      chk($sformatf("rst_cur_dw%0d", j + 1), int'(o_cur[j]), 0);
      chk($sformatf("rst_wrap_dw%0d", j + 1), int'(o_wrap[j]), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    logic [7:0] mask;
    logic [2:0] e_cur;
    logic [3:0] e_out;
    bit         e_valid;
    bit         e_wrap;
  } vec_t;

  vec_t tab [19];

  function automatic vec_t mk(input bit r, input bit e, input logic [7:0] m,
                              input logic [2:0] c, input logic [3:0] o,
                              input bit v, input bit w);
    vec_t t;
    t.rst = r; t.en = e; t.mask = m; t.e_cur = c; t.e_out = o; t.e_valid = v; t.e_wrap = w;
    return t;
  endfunction

  initial begin
    // DWELL=2 scan over mask A5, then the same with a 3-cycle freeze after edge 3.
    tab[0]  = mk(1, 1, 8'hA5, 0, 4'h1, 1, 0);
    tab[1]  = mk(0, 1, 8'hA5, 0, 4'h1, 1, 0);
    tab[2]  = mk(0, 1, 8'hA5, 2, 4'h3, 1, 0);
    tab[3]  = mk(0, 1, 8'hA5, 2, 4'h3, 1, 0);
    tab[4]  = mk(0, 1, 8'hA5, 5, 4'h6, 1, 0);
    tab[5]  = mk(0, 1, 8'hA5, 5, 4'h6, 1, 0);
    tab[6]  = mk(0, 1, 8'hA5, 7, 4'h8, 1, 0);
    tab[7]  = mk(0, 1, 8'hA5, 7, 4'h8, 1, 1);
    tab[8]  = mk(0, 1, 8'hA5, 0, 4'h1, 1, 0);
    tab[9]  = mk(1, 1, 8'hA5, 0, 4'h1, 1, 0);
    tab[10] = mk(0, 1, 8'hA5, 0, 4'h1, 1, 0);
    tab[11] = mk(0, 1, 8'hA5, 2, 4'h3, 1, 0);
    tab[12] = mk(0, 0, 8'hA5, 2, 4'h0, 0, 0);
    tab[13] = mk(0, 0, 8'hA5, 2, 4'h0, 0, 0);
    tab[14] = mk(0, 0, 8'hA5, 2, 4'h0, 0, 0);
    tab[15] = mk(0, 1, 8'hA5, 2, 4'h3, 1, 0);
    tab[16] = mk(0, 1, 8'hA5, 5, 4'h6, 1, 0);
    tab[17] = mk(0, 1, 8'hA5, 5, 4'h6, 1, 0);
    tab[18] = mk(0, 1, 8'hA5, 7, 4'h8, 1, 0);

    model_reset();
    @(posedge clk);
    #1;

    // Reset asserted mid-scan, after DWELL=1 has just wrapped.
    do_reset();
    enable = 1'b1; mode = 1'b1; ch_mask = 8'hFF;
    for (int n = 0; n < 8; n++) cycle(0);
    chk("prerst_cur_dw1", int'(o_cur[0]), 7);
    chk("prerst_wrap_dw1", int'(o_wrap[0]), 1);
    do_reset();
    cycle(0);
    chk("postrst_out_dw2", int'(o_out[1]), 1);
    chk("postrst_cur_dw2", int'(o_cur[1]), 0);

    // Direct select, then disable.
    do_reset();
    enable = 1'b1; mode = 1'b0; select = 3'd5;
    cycle(0);
    chk("dir_out", int'(o_out[1]), 6);
    chk("dir_valid", int'(o_valid[1]), 1);
    chk("dir_cur", int'(o_cur[1]), 5);
    enable = 1'b0;
    cycle(0);
    chk("dis_out", int'(o_out[1]), 0);
    chk("dis_valid", int'(o_valid[1]), 0);
    chk("dis_cur", int'(o_cur[1]), 5);

    for (int i = 0; i < 19; i++) begin
      if (tab[i].rst) do_reset();
      enable = tab[i].en; mode = 1'b1; ch_mask = tab[i].mask; select = 3'd0;
      cycle(0);
      chk($sformatf("tab%0d_cur", i), int'(o_cur[1]), int'(tab[i].e_cur));
      chk($sformatf("tab%0d_out", i), int'(o_out[1]), int'(tab[i].e_out));
      chk($sformatf("tab%0d_valid", i), int'(o_valid[1]), int'(tab[i].e_valid));
      chk($sformatf("tab%0d_wrap", i), int'(o_wrap[1]), int'(tab[i].e_wrap));
    end

    // Mask corner cases with DWELL=1.
    do_reset();
    enable = 1'b1; mode = 1'b1; ch_mask = 8'h00;
    cycle(0); cycle(0);
    chk("m0_valid", int'(o_valid[0]), 0);
    chk("m0_cur", int'(o_cur[0]), 0);
    ch_mask = 8'h10;
    cycle(0);
    chk("m10_skip_valid", int'(o_valid[0]), 0);
    chk("m10_skip_wrap", int'(o_wrap[0]), 0);
    for (int n = 0; n < 3; n++) begin
      cycle(0);
      chk($sformatf("m10_cur%0d", n), int'(o_cur[0]), 4);
      chk($sformatf("m10_out%0d", n), int'(o_out[0]), 5);
      chk($sformatf("m10_wrap%0d", n), int'(o_wrap[0]), 1);
    end
    ch_mask = 8'h01;
    cycle(0);
    chk("m01_skip_valid", int'(o_valid[0]), 0);
    chk("m01_skip_wrap", int'(o_wrap[0]), 1);
    cycle(0);
    chk("m01_cur", int'(o_cur[0]), 0);
    chk("m01_out", int'(o_out[0]), 1);

    // Scan/direct/scan with DWELL=3: dwell restarts on return.
    do_reset();
    enable = 1'b1; mode = 1'b1; ch_mask = 8'hFF;
    cycle(0);
    chk("ms_first_cur", int'(o_cur[2]), 0);
    mode = 1'b0; select = 3'd6;
    for (int n = 0; n < 2; n++) begin
      cycle(0);
      chk($sformatf("ms_dir_out%0d", n), int'(o_out[2]), 7);
    end
    mode = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle(0);
      chk($sformatf("ms_back_cur%0d", n), int'(o_cur[2]), 0);
    end
    cycle(0);
    chk("ms_adv_cur", int'(o_cur[2]), 1);
    chk("ms_adv_out", int'(o_out[2]), 2);

    // Randomized run against the reference model.
    do_reset();
    enable = 1'b1; mode = 1'b1; ch_mask = 8'hFF;
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 4) == 0) mode = ~mode;
      select = 3'($urandom_range(0, 7));
      data = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       ch_mask = 8'h00;
          1:       ch_mask = 8'h01 << $urandom_range(0, 7);
          default: ch_mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
